clock_time_digit_writer: RTL and testbench
==========================================

# clock_time_digit_writer

Receiving end of the keypad digit-entry path: consumes the cursor position and digit value produced by the keypad time-setting logic and writes them into a 14-digit BCD shadow copy of the date/time. When editing ends, it validates the whole date/time and either commits the result to the running clock with a one-cycle load pulse or rejects it. It sits between the keypad front end and the clock's time-keeping register.

## Interface
- DIGITS, 14, number of BCD digits edited. Fixed layout: 0-3 year, 4-5 month, 6-7 day, 8-9 hour, 10-11 minute, 12-13 second.
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- set_time_enable  input  1  level; high while the user is editing. Synchronous to clk.
- position  input  4  cursor digit index, 0..13
- new_value  input  4  digit value to write
- digit_strobe  input  1  one-cycle pulse; write new_value at position
- time_in  input  56  current running time, BCD, digit 0 in bits 55:52
- time_out  output  56  committed time; valid while time_load is high
- time_load  output  1  one-cycle commit pulse
- time_error  output  1  one-cycle pulse; final validation failed
- digit_reject  output  1  one-cycle pulse; strobed digit refused
- edit_active  output  1  high in the EDIT state

## Operation
- States: IDLE, EDIT, CHECK, COMMIT, REJECT.
- **IDLE:** a rising edge of set_time_enable (previous sample 0, current sample 1) moves to EDIT and copies time_in into shadow.
- **EDIT:** on digit_strobe, write new_value into shadow[position] if it is legal, otherwise pulse digit_reject.
  - Illegal: position > 13, new_value > 9, or new_value above the per-digit tens limit.
  - Tens limits: month tens ≤ 1, day tens ≤ 3, hour tens ≤ 2, minute tens ≤ 5, second tens ≤ 5.
  - set_time_enable low moves to CHECK.
- **CHECK:** one cycle of full validation.
  - month 01..12; day 01..days_in_month; hour ≤ 23.
  - Days in month: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; February 28, or 29 in a leap year.
  - Leap year: year%4==0 and (year%100!=0 or year%400==0).
  - BCD %4 test on a two-digit number: tens even requires units ∈ {0,4,8}; tens odd requires units ∈ {2,6}.
  - Year %4 uses digits 2-3. year%100==0 means digits 2-3 are both 0. year%400 applies the %4 test to digits 0-1.
  - Pass goes to COMMIT; fail goes to REJECT.
- **COMMIT:** time_load=1, time_out=shadow, then IDLE.
- **REJECT:** time_error=1, then IDLE. time_out holds its previous committed value.
- Strobes in IDLE, CHECK, COMMIT and REJECT are ignored, with no digit_reject pulse.
- A strobe in the same cycle that set_time_enable falls in EDIT is applied; CHECK sees the updated shadow.
- Rising edge of set_time_enable while in CHECK, COMMIT or REJECT: ignored. The next edit requires a fresh low-to-high transition seen in IDLE.
- Reset mid-edit: return to IDLE, clear shadow, no time_load. The running clock is untouched.

## Timing
- Reset values: time_out=0, time_load=0, time_error=0, digit_reject=0, edit_active=0, state=IDLE, shadow=0, previous-enable sample=0.
- Enable rise sampled at edge N: edit_active=1 and shadow=time_in from edge N+1.
- digit_strobe at edge N: shadow updated, or digit_reject high, for exactly the cycle after edge N.
- Enable low sampled at edge N in EDIT:
  - CHECK is the cycle after edge N.
  - time_load or time_error is high for the single cycle after edge N+1.
  - IDLE from edge N+2 onward.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package clock_time_pkg holds:
  - DIGITS;
  - position constants: POS_YEAR0, POS_MONTH_T, POS_DAY_T, POS_HOUR_T, POS_MIN_T, POS_SEC_T;
  - the per-position maximum-digit function;
  - the state enumeration.
- Sub-module clock_date_validator: combinational. Takes the 56-bit shadow, returns valid; contains the leap-year and days-in-month logic. It is verified standalone.

## Test plan
- Reset, time_in=2023-06-15 10:20:30 → raise enable, strobe pos 9 val 5, drop enable → time_out=2023-06-15 15:20:30, time_load high for one cycle, two cycles after enable drop.
- Strobe pos 8 val 3 → digit_reject pulse, shadow unchanged. Strobe pos 14 val 1 → digit_reject pulse. Strobe val 10 → digit_reject pulse.
- Date edited to 2023-02-29, then exit → time_error pulse, no time_load. Same with year 2024 → commit. Year 1900 with 02-29 → error. Year 2000 with 02-29 → commit.
- Month edited to 13 (digits 1,3), then exit → time_error. Day edited to 00 → time_error.
- Assert rst two cycles into EDIT after writes → all outputs 0, state IDLE. A later edit starts from the current time_in.
- Strobe in the same cycle enable falls → the written digit appears in time_out. A strobe during CHECK → no effect and no digit_reject.

Source files
------------

// File: rtl/clock_time_digit_writer_pkg.sv
// Shared definitions for the keypad date/time digit writer: digit layout,
// per-digit entry limits and the edit state machine encoding.
package clock_time_pkg;

  localparam int DIGITS      = 14;
  localparam int POS_YEAR0   = 0;
  localparam int POS_MONTH_T = 4;
  localparam int POS_DAY_T   = 6;
  localparam int POS_HOUR_T  = 8;
  localparam int POS_MIN_T   = 10;
  localparam int POS_SEC_T   = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT,
    ST_CHECK,
    ST_COMMIT,
    ST_REJECT
  } state_t;

  // Largest value a single keypress may place at a digit position.
  function automatic logic [3:0] max_digit(input logic [3:0] pos);
    case (pos)
      4'(POS_MONTH_T): return 4'd1;
      4'(POS_DAY_T):   return 4'd3;
      4'(POS_HOUR_T):  return 4'd2;
      4'(POS_MIN_T):   return 4'd5;
      4'(POS_SEC_T):   return 4'd5;
      default:         return 4'd9;
    endcase
  endfunction

  // Digit idx of a packed date/time word; digit 0 is the most significant.
  function automatic logic [3:0] digit_of(input logic [DIGITS*4-1:0] t, input int idx);
    return t[(DIGITS-1-idx)*4 +: 4];
  endfunction

endpackage

// File: rtl/clock_date_validator.sv
// Combinational check of a full BCD date/time: month range, day against the
// length of the month (with Gregorian leap years) and hour range.
module clock_date_validator
  import clock_time_pkg::*;
(
  input  logic [DIGITS*4-1:0] shadow,
  output logic                valid
);

  logic [3:0] y0, y1, y2, y3, mt, mu, dt, du, ht, hu;
  logic [7:0] month, day, hour, days_in_month;
  logic       leap;

  // Divisibility by 4 of a two-digit BCD number without a binary conversion.
  function automatic logic div4(input logic [3:0] tens, input logic [3:0] units);
    if (!tens[0]) return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
    else          return (units == 4'd2) || (units == 4'd6);
  endfunction

  function automatic logic [7:0] to_bin(input logic [3:0] tens, input logic [3:0] units);
    return 8'(tens) * 8'd10 + 8'(units);
  endfunction

  assign y0 = digit_of(shadow, POS_YEAR0);
  assign y1 = digit_of(shadow, POS_YEAR0 + 1);
  assign y2 = digit_of(shadow, POS_YEAR0 + 2);
  assign y3 = digit_of(shadow, POS_YEAR0 + 3);
  assign mt = digit_of(shadow, POS_MONTH_T);
  assign mu = digit_of(shadow, POS_MONTH_T + 1);
  assign dt = digit_of(shadow, POS_DAY_T);
  assign du = digit_of(shadow, POS_DAY_T + 1);
  assign ht = digit_of(shadow, POS_HOUR_T);
  assign hu = digit_of(shadow, POS_HOUR_T + 1);

  assign month = to_bin(mt, mu);
  assign day   = to_bin(dt, du);
  assign hour  = to_bin(ht, hu);

  // A century year is only a leap year when the century itself divides by 4.
  assign leap = div4(y2, y3) && (!((y2 == 4'd0) && (y3 == 4'd0)) || div4(y0, y1));

  always_comb begin
    days_in_month = 8'd0;
    case (month)
      8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: days_in_month = 8'd31;
      8'd4, 8'd6, 8'd9, 8'd11:                    days_in_month = 8'd30;
      8'd2:    days_in_month = leap ? 8'd29 : 8'd28;
      default: days_in_month = 8'd0;
    endcase
  end

  assign valid = (month >= 8'd1) && (month <= 8'd12) &&
                 (day >= 8'd1) && (day <= days_in_month) &&
                 (hour <= 8'd23);

endmodule

// File: rtl/clock_time_digit_writer.sv
// Keypad-side shadow of the date/time: takes digit writes while editing,
// validates on exit and either loads the running clock or flags an error.
module clock_time_digit_writer
  import clock_time_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_time_enable,
  input  logic [3:0]          position,
  input  logic [3:0]          new_value,
  input  logic                digit_strobe,
  input  logic [DIGITS*4-1:0] time_in,
  output logic [DIGITS*4-1:0] time_out,
  output logic                time_load,
  output logic                time_error,
  output logic                digit_reject,
  output logic                edit_active
);

  state_t              state;
  logic [DIGITS*4-1:0] shadow;
  logic                enable_prev;
  logic                shadow_valid;
  logic                digit_legal;

  clock_date_validator u_validator (
    .shadow (shadow),
    .valid  (shadow_valid)
  );

  assign digit_legal = (position <= 4'(DIGITS - 1)) && (new_value <= max_digit(position));

  // Pulses default low each cycle; only the state that owns a pulse raises it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      shadow       <= '0;
      enable_prev  <= 1'b0;
      time_out     <= '0;
      time_load    <= 1'b0;
      time_error   <= 1'b0;
      digit_reject <= 1'b0;
      edit_active  <= 1'b0;
    end else begin
      enable_prev  <= set_time_enable;
      time_load    <= 1'b0;
      time_error   <= 1'b0;
      digit_reject <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (set_time_enable && !enable_prev) begin
            state       <= ST_EDIT;
            shadow      <= time_in;
            edit_active <= 1'b1;
          end
        end
        ST_EDIT: begin
          if (digit_strobe) begin
            if (digit_legal) begin
              for (int i = 0; i < DIGITS; i++)
                if (position == 4'(i)) shadow[(DIGITS-1-i)*4 +: 4] <= new_value;
            end else begin
              digit_reject <= 1'b1;
            end
          end
          if (!set_time_enable) begin
            state       <= ST_CHECK;
            edit_active <= 1'b0;
          end
        end
        // The result pulse is registered here so it is visible during COMMIT/REJECT.
        ST_CHECK: begin
          if (shadow_valid) begin
            state     <= ST_COMMIT;
            time_out  <= shadow;
            time_load <= 1'b1;
          end else begin
            state      <= ST_REJECT;
            time_error <= 1'b1;
          end
        end
        ST_COMMIT: state <= ST_IDLE;
        ST_REJECT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_digit_writer.sv
// Self-checking bench for clock_time_digit_writer: a directed vector table,
// hand-written reset/CHECK-window sequences and random edits against a date model.
module tb_clock_time_digit_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_time_enable;
  logic [3:0]  position;
  logic [3:0]  new_value;
  logic        digit_strobe;
  logic [55:0] time_in;
  logic [55:0] time_out;
  logic        time_load;
  logic        time_error;
  logic        digit_reject;
  logic        edit_active;

  int n_checks = 0;
  int n_pass   = 0;
  logic [55:0] model_out;

  typedef struct {
    logic [55:0]     tin;
    int              n;
    logic [3:0][3:0] pos;
    logic [3:0][3:0] val;
    bit              on_fall;
    logic [3:0]      exp_rej;
    bit              exp_load;
    logic [55:0]     exp_out;
  } vec_t;

  vec_t vecs[9];

  clock_time_digit_writer dut (
    .clk             (clk),
    .rst             (rst),
    .set_time_enable (set_time_enable),
    .position        (position),
    .new_value       (new_value),
    .digit_strobe    (digit_strobe),
    .time_in         (time_in),
    .time_out        (time_out),
    .time_load       (time_load),
    .time_error      (time_error),
    .digit_reject    (digit_reject),
    .edit_active     (edit_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [55:0] act, input logic [55:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference rules, written directly from calendar arithmetic.
  function automatic bit digit_ok(input int p, input int v);
    if (p > 13 || v > 9) return 1'b0;
    case (p)
      4:       return v <= 1;
      6:       return v <= 3;
      8:       return v <= 2;
      10, 12:  return v <= 5;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit date_ok(input logic [55:0] t);
    int d[14];
    int year, month, day, hour, dim;
    int dim_tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    bit leap;
    for (int i = 0; i < 14; i++) d[i] = int'(t[55-4*i -: 4]);
    year  = d[0]*1000 + d[1]*100 + d[2]*10 + d[3];
    month = d[4]*10 + d[5];
    day   = d[6]*10 + d[7];
    hour  = d[8]*10 + d[9];
    if (month < 1 || month > 12) return 1'b0;
    leap = (year % 4 == 0) && ((year % 100 != 0) || (year % 400 == 0));
    dim  = dim_tab[month-1] + ((month == 2 && leap) ? 1 : 0);
    return (day >= 1) && (day <= dim) && (hour <= 23);
  endfunction

  function automatic vec_t mk(input logic [55:0] tin, input int n,
                              input int p0, input int v0, input int p1, input int v1,
                              input int p2, input int v2, input bit on_fall,
                              input logic [3:0] rej, input bit load, input logic [55:0] out);
    vec_t v;
    v.tin = tin; v.n = n; v.on_fall = on_fall; v.exp_rej = rej;
    v.exp_load = load; v.exp_out = out;
    v.pos = '0; v.val = '0;
    v.pos[0] = 4'(p0); v.val[0] = 4'(v0);
    v.pos[1] = 4'(p1); v.val[1] = 4'(v1);
    v.pos[2] = 4'(p2); v.val[2] = 4'(v2);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    time_in = v.tin; set_time_enable = 1'b0; digit_strobe = 1'b0;
    tick();
    set_time_enable = 1'b1;
    tick();
    checkOutput("edit_active_on", 56'(edit_active), 56'd1);
    for (int i = 0; i < v.n; i++) begin
      if (v.on_fall && i == v.n - 1) set_time_enable = 1'b0;
      position = v.pos[i]; new_value = v.val[i]; digit_strobe = 1'b1;
      tick();
      digit_strobe = 1'b0;
      checkOutput("digit_reject", 56'(digit_reject), 56'(v.exp_rej[i]));
    end
    if (set_time_enable) begin
      set_time_enable = 1'b0;
      tick();
    end
    checkOutput("check_cycle_quiet", 56'({edit_active, time_load, time_error}), 56'd0);
    tick();
    checkOutput("time_load", 56'(time_load), 56'(v.exp_load));
    checkOutput("time_error", 56'(time_error), 56'(!v.exp_load));
    checkOutput("time_out", time_out, v.exp_out);
    tick();
    checkOutput("pulse_end", 56'({time_load, time_error}), 56'd0);
    checkOutput("time_out_hold", time_out, v.exp_out);
    if (v.exp_load) model_out = v.exp_out;
  endtask

  initial begin
    vec_t rv;
    logic [55:0] sh;
    int p, val;

    rst = 1'b1; set_time_enable = 1'b0; position = '0; new_value = '0;
    digit_strobe = 1'b0; time_in = '0;
    tick(); tick();
    checkOutput("reset_time_out", time_out, 56'd0);
    checkOutput("reset_pulses", 56'({time_load, time_error, digit_reject, edit_active}), 56'd0);
    rst = 1'b0;
    model_out = '0;

    vecs[0] = mk(56'h20230615102030, 1, 9, 5, 0, 0, 0, 0, 0, 4'b0000, 1, 56'h20230615152030);
    vecs[1] = mk(56'h20230615102030, 3, 8, 3, 14, 1, 0, 10, 0, 4'b0111, 1, 56'h20230615102030);
    vecs[2] = mk(56'h20230615102030, 3, 5, 2, 6, 2, 7, 9, 0, 4'b0000, 0, 56'h20230615102030);
    vecs[3] = mk(56'h20240615102030, 3, 5, 2, 6, 2, 7, 9, 0, 4'b0000, 1, 56'h20240229102030);
    vecs[4] = mk(56'h19000615102030, 3, 5, 2, 6, 2, 7, 9, 0, 4'b0000, 0, 56'h20240229102030);
    vecs[5] = mk(56'h20000615102030, 3, 5, 2, 6, 2, 7, 9, 1, 4'b0000, 1, 56'h20000229102030);
    vecs[6] = mk(56'h20230615102030, 2, 4, 1, 5, 3, 0, 0, 0, 4'b0000, 0, 56'h20000229102030);
    vecs[7] = mk(56'h20230615102030, 2, 6, 0, 7, 0, 0, 0, 0, 4'b0000, 0, 56'h20000229102030);
    vecs[8] = mk(56'h20230615102030, 1, 13, 9, 0, 0, 0, 0, 1, 4'b0000, 1, 56'h20230615102039);
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Strobe and a new enable rise during CHECK are both ignored.
    $display("[TB] CHECK-window sequence");
    time_in = 56'h20230615102030; tick();
    set_time_enable = 1'b1; tick();
    position = 4'd9; new_value = 4'd5; digit_strobe = 1'b1; tick();
    digit_strobe = 1'b0; set_time_enable = 1'b0; tick();
    position = 4'd13; new_value = 4'd1; digit_strobe = 1'b1; set_time_enable = 1'b1; tick();
    digit_strobe = 1'b0;
    checkOutput("check_strobe_reject", 56'(digit_reject), 56'd0);
    checkOutput("check_strobe_load", 56'(time_load), 56'd1);
    checkOutput("check_strobe_out", time_out, 56'h20230615152030);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("no_edit_from_stale_rise", 56'({edit_active, time_load}), 56'd0);
    end
    set_time_enable = 1'b0; tick(); tick();
    model_out = 56'h20230615152030;

    // Reset in the middle of an edit.
    $display("[TB] reset mid-edit sequence");
    time_in = 56'h20230615102030; tick();
    set_time_enable = 1'b1; tick();
    position = 4'd9; new_value = 4'd5; digit_strobe = 1'b1; tick();
    position = 4'd13; new_value = 4'd1; tick();
    digit_strobe = 1'b0; tick(); tick();
    rst = 1'b1; set_time_enable = 1'b0; tick();
    checkOutput("midreset_time_out", time_out, 56'd0);
    checkOutput("midreset_pulses", 56'({time_load, time_error, digit_reject, edit_active}), 56'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("after_reset_idle", 56'({time_load, time_error, edit_active}), 56'd0);
    end
    model_out = '0;
    applyStimulus(mk(56'h20240101000000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 56'h20240101000000));

    // Random edits against the calendar model.
    for (int k = 0; k < 40; k++) begin
      sh = '0;
      for (int i = 0; i < 4; i++) sh[55-4*i -: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0) sh[39:32] = 8'h02;
      else begin sh[39:36] = 4'($urandom_range(0, 1)); sh[35:32] = 4'($urandom_range(0, 9)); end
      sh[31:28] = 4'($urandom_range(0, 3)); sh[27:24] = 4'($urandom_range(0, 9));
      sh[23:20] = 4'($urandom_range(0, 2)); sh[19:16] = 4'($urandom_range(0, 9));
      sh[15:12] = 4'($urandom_range(0, 5)); sh[11:8]  = 4'($urandom_range(0, 9));
      sh[7:4]   = 4'($urandom_range(0, 5)); sh[3:0]   = 4'($urandom_range(0, 9));
      rv = mk(sh, $urandom_range(0, 3), 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 56'd0);
      rv.on_fall = (rv.n > 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < rv.n; i++) begin
        p = $urandom_range(0, 14); val = $urandom_range(0, 10);
        rv.pos[i] = 4'(p); rv.val[i] = 4'(val);
        if (digit_ok(p, val)) sh[55-4*p -: 4] = 4'(val);
        else rv.exp_rej[i] = 1'b1;
      end
      rv.exp_load = date_ok(sh);
      rv.exp_out  = rv.exp_load ? sh : model_out;
      applyStimulus(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
